// File: rtl/cpu_bus_master_pkg.sv
// Shared types and defaults for the 6809-style bus master: phase encoding,
// idle address and stretch counter sizing.
package cpu_bus_master_pkg;

   typedef enum logic [1:0] {
      P0 = 2'd0,
      P1 = 2'd1,
      P2 = 2'd2,
      P3 = 2'd3
   } phase_t;

   localparam logic [15:0] IDLE_ADDR_DEFAULT   = 16'hFFFF;
   localparam int          MAX_STRETCH_DEFAULT = 8;
   localparam int          STRETCH_W           = 8;

   // E is high in the second half of the cycle, Q leads it by one phase.
   function automatic logic phase_e(input phase_t p);
      return (p == P2) || (p == P3);
   endfunction

   function automatic logic phase_q(input phase_t p);
      return (p == P1) || (p == P2);
   endfunction

endpackage

// File: rtl/cpu_bus_master_if.sv
// Request-side handshake and 6809 bus pins grouped in one bundle; the master
// modport is the bus master's view, the slave modport the environment's.
interface cpu_bus_master_if;

   logic        req;
   logic        req_rnw;
   logic [15:0] req_addr;
   logic [7:0]  req_wdata;
   logic        ack;
   logic        err;
   logic [7:0]  rdata;

   logic [15:0] addr;
   logic        rnw;
   logic        e;
   logic        q;
   logic        ba;
   logic        bs;
   logic [7:0]  data_in;
   logic [7:0]  data_out;
   logic        data_oe;
   logic        mrdy;

   modport master (
      input  req, req_rnw, req_addr, req_wdata, data_in, mrdy,
      output ack, err, rdata, addr, rnw, e, q, ba, bs, data_out, data_oe
   );

   modport slave (
      output req, req_rnw, req_addr, req_wdata, data_in, mrdy,
      input  ack, err, rdata, addr, rnw, e, q, ba, bs, data_out, data_oe
   );

endinterface

// File: rtl/cpu_bus_master_bus_phase_gen.sv
// Four-phase quadrature generator with MRDY stretch in P3 and a bounded
// stretch counter that forces the cycle to end on timeout.
//
// state | meaning
// P0    | E=0 Q=0, address setup
// P1    | E=0 Q=1
// P2    | E=1 Q=1
// P3    | E=1 Q=0, MRDY sampled on exit, held here while stretching
module bus_phase_gen
   import cpu_bus_master_pkg::*;
#(
   parameter int MAX_STRETCH = MAX_STRETCH_DEFAULT
) (
   input  logic   clkx4,
   input  logic   reset,
   input  logic   mrdy,
   output phase_t phase,
   output logic   e,
   output logic   q,
   output logic   cycle_end,
   output logic   timeout
);

   localparam logic [STRETCH_W-1:0] STRETCH_LIMIT = STRETCH_W'(MAX_STRETCH);

   phase_t               phase_nxt;
   logic [STRETCH_W-1:0] stretch_cnt;
   logic [STRETCH_W-1:0] stretch_cnt_nxt;
   logic                 limit_hit;

   assign limit_hit = (stretch_cnt == STRETCH_LIMIT);
   assign cycle_end = (phase == P3) && (mrdy || limit_hit);
   // A ready memory on the limit edge still counts as a normal completion.
   assign timeout   = (phase == P3) && limit_hit && !mrdy;

   always_comb begin
      phase_nxt       = phase;
      stretch_cnt_nxt = stretch_cnt;
      case (phase)
         P0: phase_nxt = P1;
         P1: phase_nxt = P2;
         P2: phase_nxt = P3;
         P3: begin
            if (cycle_end) begin
               phase_nxt       = P0;
               stretch_cnt_nxt = '0;
            end else begin
               stretch_cnt_nxt = stretch_cnt + 1'b1;
            end
         end
         default: phase_nxt = P0;
      endcase
   end

   always_ff @(posedge clkx4) begin
      if (reset) begin
         phase       <= P0;
         stretch_cnt <= '0;
         e           <= 1'b0;
         q           <= 1'b0;
      end else begin
         phase       <= phase_nxt;
         stretch_cnt <= stretch_cnt_nxt;
         e           <= phase_e(phase_nxt);
         q           <= phase_q(phase_nxt);
      end
   end

endmodule

// File: rtl/cpu_bus_master.sv
// 6809-style bus master: captures one request per bus cycle at P0 entry,
// drives address/direction/write data and returns ACK/ERR/RDATA.
module cpu_bus_master
   import cpu_bus_master_pkg::*;
#(
   parameter logic [15:0] IDLE_ADDR   = IDLE_ADDR_DEFAULT,
   parameter int          MAX_STRETCH = MAX_STRETCH_DEFAULT
) (
   input  logic             clkx4,
   input  logic             reset,
   cpu_bus_master_if.master bus
);

   phase_t      phase;
   logic        e;
   logic        q;
   logic        cycle_end;
   logic        timeout;

   logic        active;
   logic [15:0] addr_q;
   logic        rnw_q;
   logic [7:0]  wdata_q;
   logic        ack_q;
   logic        err_q;
   logic [7:0]  rdata_q;
   logic [7:0]  data_out_q;
   logic        data_oe_q;

   bus_phase_gen #(
      .MAX_STRETCH (MAX_STRETCH)
   ) u_phase (
      .clkx4     (clkx4),
      .reset     (reset),
      .mrdy      (bus.mrdy),
      .phase     (phase),
      .e         (e),
      .q         (q),
      .cycle_end (cycle_end),
      .timeout   (timeout)
   );

   always_ff @(posedge clkx4) begin
      if (reset) begin
         active     <= 1'b0;
         addr_q     <= IDLE_ADDR;
         rnw_q      <= 1'b1;
         wdata_q    <= '0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         rdata_q    <= '0;
         data_out_q <= '0;
         data_oe_q  <= 1'b0;
      end else begin
         ack_q <= 1'b0;
         err_q <= 1'b0;

         if ((phase == P0) && active && !rnw_q) begin
            data_oe_q  <= 1'b1;
            data_out_q <= wdata_q;
         end

         if (cycle_end) begin
            data_oe_q <= 1'b0;
            if (active) begin
               ack_q <= 1'b1;
               err_q <= timeout;
               if (rnw_q && !timeout) begin
                  rdata_q <= bus.data_in;
               end
            end
            // The request completing on this edge may still show REQ high;
            // it must not be taken again until the following P0 entry.
            if (bus.req && !active) begin
               active  <= 1'b1;
               addr_q  <= bus.req_addr;
               rnw_q   <= bus.req_rnw;
               wdata_q <= bus.req_wdata;
            end else begin
               active  <= 1'b0;
               addr_q  <= IDLE_ADDR;
               rnw_q   <= 1'b1;
            end
         end
      end
   end

   assign bus.addr     = addr_q;
   assign bus.rnw      = rnw_q;
   assign bus.e        = e;
   assign bus.q        = q;
   assign bus.ba       = 1'b0;
   assign bus.bs       = 1'b0;
   assign bus.data_out = data_out_q;
   assign bus.data_oe  = data_oe_q;
   assign bus.ack      = ack_q;
   assign bus.err      = err_q;
   assign bus.rdata    = rdata_q;

endmodule

// File: tb/tb_cpu_bus_master.sv
// Directed bench for cpu_bus_master: a vector table of single transactions
// plus hand sequences for reset, back-to-back requests and reset abort.
module tb_cpu_bus_master;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cpu_bus_master_if bus();

   cpu_bus_master #(
      .IDLE_ADDR   (16'hFFFF),
      .MAX_STRETCH (8)
   ) dut (
      .clkx4 (clk),
      .reset (rst),
      .bus   (bus.master)
   );

   int errors = 0;
   int checks = 0;
   logic [7:0] exp_rdata;

   typedef struct {
      logic        rnw;
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  din;
      int          low;
      logic        exp_err;
      int          exp_ehigh;
      logic [7:0]  exp_rdata;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_txn(input vec_t v);
      int   p3_seen = 0;
      int   ehigh = 0;
      int   cyc = 0;
      bit   started = 0;
      bit   done = 0;
      bus.req_rnw   = v.rnw;
      bus.req_addr  = v.addr;
      bus.req_wdata = v.wdata;
      bus.data_in   = v.din;
      bus.mrdy      = 1'b1;
      bus.req       = 1'b1;
      for (int i = 0; i < 60 && !done; i++) begin
         tick();
         if (!started && bus.e == 1'b0 && bus.q == 1'b0 && bus.addr !== 16'hFFFF)
            started = 1;
         if (started) begin
            if (bus.ack === 1'b1) begin
               done = 1;
               chk("txn_cycles", cyc, v.exp_ehigh + 2);
               chk("txn_e_high", ehigh, v.exp_ehigh);
               chk("txn_err", bus.err, v.exp_err);
               chk("txn_rdata", bus.rdata, v.exp_rdata);
               chk("txn_no_accept_on_ack", bus.addr, 16'hFFFF);
               chk("txn_oe_p0", bus.data_oe, 1'b0);
               bus.req  = 1'b0;
               bus.mrdy = 1'b1;
            end else begin
               cyc++;
               if (bus.e) ehigh++;
               chk("txn_addr", bus.addr, v.addr);
               chk("txn_rnw", bus.rnw, v.rnw);
               if (v.rnw) begin
                  chk("txn_read_oe", bus.data_oe, 1'b0);
               end else begin
                  chk("txn_write_oe", bus.data_oe, bus.e | bus.q);
                  if (bus.e | bus.q) chk("txn_data_out", bus.data_out, v.wdata);
               end
               if (bus.e && !bus.q) begin
                  p3_seen++;
                  bus.mrdy = (p3_seen > v.low);
               end
            end
         end
      end
      if (!done) begin
         chk("txn_ack_timeout", 0, 1);
         bus.req  = 1'b0;
         bus.mrdy = 1'b1;
      end
      tick();
      chk("txn_ack_single", bus.ack, 1'b0);
   endtask

   initial begin
      int acks;
      int n;
      bit got;

      vecs[0] = '{1'b1, 16'hFE00, 8'h00, 8'h5A, 0,  1'b0, 2,  8'h5A};
      vecs[1] = '{1'b0, 16'h1234, 8'hA5, 8'h00, 0,  1'b0, 2,  8'h5A};
      vecs[2] = '{1'b1, 16'h00C3, 8'h00, 8'h3C, 3,  1'b0, 5,  8'h3C};
      vecs[3] = '{1'b1, 16'h8001, 8'h00, 8'h77, 20, 1'b1, 10, 8'h3C};
      vecs[4] = '{1'b0, 16'h0000, 8'hFF, 8'h11, 2,  1'b0, 4,  8'h3C};
      vecs[5] = '{1'b1, 16'h4321, 8'h00, 8'h99, 7,  1'b0, 9,  8'h99};

      rst = 1'b1;
      bus.req = 1'b0;
      bus.req_rnw = 1'b1;
      bus.req_addr = 16'h0000;
      bus.req_wdata = 8'h00;
      bus.data_in = 8'h00;
      bus.mrdy = 1'b1;
      repeat (3) tick();
      chk("rst_e", bus.e, 1'b0);
      chk("rst_q", bus.q, 1'b0);
      chk("rst_addr", bus.addr, 16'hFFFF);
      chk("rst_rnw", bus.rnw, 1'b1);
      chk("rst_oe", bus.data_oe, 1'b0);
      chk("rst_data_out", bus.data_out, 8'h00);
      chk("rst_ack", bus.ack, 1'b0);
      chk("rst_err", bus.err, 1'b0);
      chk("rst_rdata", bus.rdata, 8'h00);
      chk("rst_ba_bs", {bus.ba, bus.bs}, 2'b00);
      rst = 1'b0;
      tick();
      chk("post_rst_p1", {bus.e, bus.q}, 2'b01);
      tick();
      chk("post_rst_p2", {bus.e, bus.q}, 2'b11);
      tick();
      chk("post_rst_p3", {bus.e, bus.q}, 2'b10);
      tick();
      chk("post_rst_p0", {bus.e, bus.q}, 2'b00);
      chk("dead_addr", bus.addr, 16'hFFFF);

      for (int i = 0; i < 6; i++) run_txn(vecs[i]);
      exp_rdata = 8'h99;

      // REQ held high across two transactions
      bus.req_rnw = 1'b1;
      bus.req_addr = 16'h2222;
      bus.data_in = 8'h44;
      bus.mrdy = 1'b1;
      bus.req = 1'b1;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         tick();
         if (bus.ack === 1'b1) got = 1;
      end
      chk("b2b_first_ack", got, 1'b1);
      chk("b2b_ack_edge_addr", bus.addr, 16'hFFFF);
      chk("b2b_ack_edge_rnw", bus.rnw, 1'b1);
      chk("b2b_rdata1", bus.rdata, 8'h44);
      got = 0;
      n = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         tick();
         n++;
         if (n == 4) chk("b2b_second_addr", bus.addr, 16'h2222);
         if (bus.ack === 1'b1) got = 1;
      end
      chk("b2b_second_ack", got, 1'b1);
      chk("b2b_spacing", n, 8);
      bus.req = 1'b0;
      tick();
      chk("idle_addr", bus.addr, 16'hFFFF);
      chk("idle_rnw", bus.rnw, 1'b1);
      exp_rdata = 8'h44;
      chk("idle_rdata_held", bus.rdata, exp_rdata);

      // reset during P2 of a write
      bus.req_rnw = 1'b0;
      bus.req_addr = 16'h5555;
      bus.req_wdata = 8'h66;
      bus.req = 1'b1;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         tick();
         if (bus.addr === 16'h5555 && bus.e && bus.q) got = 1;
      end
      chk("rstmid_reach_p2", got, 1'b1);
      chk("rstmid_oe_before", bus.data_oe, 1'b1);
      rst = 1'b1;
      tick();
      chk("rstmid_eq", {bus.e, bus.q}, 2'b00);
      chk("rstmid_oe", bus.data_oe, 1'b0);
      chk("rstmid_addr", bus.addr, 16'hFFFF);
      chk("rstmid_ack", bus.ack, 1'b0);
      chk("rstmid_rdata", bus.rdata, 8'h00);
      bus.req = 1'b0;
      tick();
      rst = 1'b0;
      acks = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus.ack === 1'b1) acks++;
      end
      chk("rstmid_no_ack", acks, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cpu_bus_master.md
CPU_BUS_MASTER -- requirements
Module: cpu_bus_master

Interface
REQ-001 Parameter IDLE_ADDR, default 16'hFFFF, address driven during dead (no-request) bus cycles.
REQ-002 Parameter MAX_STRETCH, default 8, maximum CLKX4 periods E is held high by MRDY before abort.
REQ-003 Clocking: one clock, CLKX4; reset RESET is synchronous and active-high.
REQ-004 CLKX4  in  1  master clock, four periods per unstretched bus cycle.
REQ-005 RESET  in  1  synchronous active-high reset.
REQ-006 REQ  in  1  transaction request, held high with REQ_* stable until ACK.
REQ-007 REQ_RnW  in  1  1 = read, 0 = write.
REQ-008 REQ_ADDR  in  16  transaction address.
REQ-009 REQ_WDATA  in  8  write data.
REQ-010 ACK  out  1  one-CLKX4 pulse, transaction complete.
REQ-011 ERR  out  1  qualifies ACK, MRDY timeout.
REQ-012 RDATA  out  8  read data, valid while ACK high and held until next ACK.
REQ-013 ADDR  out  16  bus address.
REQ-014 RnW  out  1  bus direction.
REQ-015 E, Q  out  1 each  6809 quadrature bus clocks.
REQ-016 BA, BS  out  1 each  status, both constant 0 (normal running).
REQ-017 DATA_in  in  8; DATA_out  out  8; DATA_oe  out  1  split tristate data bus.
REQ-018 MRDY  in  1  memory ready, low = stretch.

Function
REQ-019 Cycle = phases P0..P3, one CLKX4 each: P0 E=0 Q=0; P1 E=0 Q=1; P2 E=1 Q=1; P3 E=1 Q=0; then P0 again.
REQ-020 E and Q SHALL be registered outputs, decoded from the phase register.
REQ-021 Bus cycles run continuously; with no request each cycle SHALL be a dead cycle: ADDR=IDLE_ADDR, RnW=1, DATA_oe=0.
REQ-022 Acceptance: on the edge entering P0, if REQ=1 and no ACK is issued on that same edge, REQ_* SHALL be captured and drive ADDR/RnW for the whole cycle.
REQ-023 The cycle completing on that edge issues ACK; REQ may still be high then, so a new request SHALL only be accepted on a later P0 entry (at most one transaction per bus cycle, none back-to-back on the ACK edge).
REQ-024 Writes: DATA_out=captured data and DATA_oe=1 from P1 entry until E falls, inclusive of any stretch; DATA_oe=0 in P0.
REQ-025 Reads: DATA_in SHALL be sampled into RDATA on the edge leaving P3 (E falling).
REQ-026 ACK=1 for exactly the CLKX4 period following the edge leaving P3 of an accepted cycle; ERR=0 on normal completion.
REQ-027 MRDY is sampled on each edge leaving P3; if 0, phase stays P3 (E=1, Q=0) and a stretch counter increments.
REQ-028 Stretch ends on the first edge where MRDY=1; the cycle then completes per REQ-025/026.
REQ-029 When the stretch count reaches MAX_STRETCH, the cycle SHALL end regardless of MRDY, with ACK=1, ERR=1 and RDATA unchanged.
REQ-030 Dead cycles also honour MRDY stretch and timeout but never assert ACK or ERR.
REQ-031 Unstretched throughput: one transaction per 4 CLKX4; request-to-ACK latency is 4..7 clocks (alignment dependent) plus stretch.

Reset
REQ-032 RESET=1 forces phase P0, E=0, Q=0, ADDR=IDLE_ADDR, RnW=1, DATA_oe=0, DATA_out=0, ACK=0, ERR=0, RDATA=0, stretch count 0.
REQ-033 RESET during an active transaction SHALL abort it with no ACK; the requester re-presents REQ after reset.
REQ-034 The first edge after RESET falls enters P1 (the cycle starting from P0 held during reset is a dead cycle).

Structure
REQ-035 Shared package: phase enumeration (P0..P3), IDLE_ADDR default, stretch counter width.
REQ-036 One sub-module, bus_phase_gen: phase register, E/Q decode, MRDY stretch counter, timeout flag. cpu_bus_master owns request capture, bus drive and ACK/RDATA.

Verification
REQ-037 Read 0xFE00, MRDY=1, DATA_in=0x5A at E fall -> ADDR=FE00 and RnW=1 for 4 clocks, ACK one clock, RDATA=0x5A, ERR=0.
REQ-038 Write 0x1234 <- 0xA5 -> RnW=0, DATA_oe=1 and DATA_out=A5 from P1 through P3, DATA_oe=0 in P0, single ACK.
REQ-039 Read with MRDY low for 3 clocks in P3 -> E high for 5 clocks, RDATA taken on the release edge, ACK after release.
REQ-040 MRDY stuck low with MAX_STRETCH=8 -> E high 2+8 clocks, ACK=1 and ERR=1, RDATA unchanged.
REQ-041 REQ held high across two transactions -> no acceptance on the ACK edge; second cycle starts at the next P0; no request -> ADDR=FFFF, RnW=1.
REQ-042 RESET asserted in P2 of a write -> next clock E=0, Q=0, DATA_oe=0, ADDR=FFFF, no ACK.
